instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the instruction address width (halfword-addressed).
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 4, meaning prefetch queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter INSTRUCTION_WIDTH, default 16, meaning instruction word width.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clock, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port mem_req, output, 1 bit: fetch request, combinational.
REQ-008 The block SHALL have port mem_addr, output, ADDR_WIDTH bits: fetch address, equal to fetch_pc.
REQ-009 The block SHALL have port mem_data, input, INSTRUCTION_WIDTH bits: read data, valid the cycle after the request.
REQ-010 The block SHALL have port Instruction, output, INSTRUCTION_WIDTH bits: queue head, feeds the decoder.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: Instruction is meaningful.
REQ-012 The block SHALL have port instr_pc, output, ADDR_WIDTH bits: address of the head instruction.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: the decode stage consumes the head this cycle.
REQ-014 The block SHALL have port redirect, input, 1 bit: branch taken, flush and refetch.
REQ-015 The block SHALL have port redirect_target, input, ADDR_WIDTH bits: new fetch address.
REQ-016 The block SHALL have port halt, input, 1 bit: stop issuing fetches (HLT executed).

Function
REQ-017 The block SHALL assert mem_req when halt=0, redirect=0 and count+inflight < QUEUE_DEPTH; inflight = mem_req was issued last cycle and is not cancelled.
REQ-018 Each issued request SHALL advance fetch_pc by 1 at the clock edge, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-019 A non-cancelled response SHALL be pushed with its address into the queue at the edge ending the cycle in which mem_data is valid.
REQ-020 A pop SHALL occur when instr_valid=1 and instr_ready=1; instr_ready with instr_valid=0 SHALL be ignored.
REQ-021 A push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-022 The credit rule of REQ-017 SHALL guarantee no push when full; the queue SHALL never overflow or underflow.
REQ-023 instr_valid SHALL equal (count != 0); Instruction and instr_pc SHALL be driven from the head entry.
REQ-024 Fetch latency SHALL be 2 cycles: request in cycle N -> instr_valid in cycle N+2 when the queue was empty.
REQ-025 Redirect sampled at edge R SHALL clear the queue, set fetch_pc=redirect_target and cancel the response arriving in cycle R+1; the first target instruction SHALL be valid in cycle R+3.
REQ-026 Redirect SHALL take priority over a simultaneous pop, push or halt; mem_req SHALL be 0 in the redirect cycle.
REQ-027 Halt SHALL block new requests only; the in-flight response SHALL still be pushed and the queue SHALL continue to drain.

Reset
REQ-028 Reset SHALL asynchronously clear fetch_pc, pointers, count and inflight to 0; outputs SHALL be mem_req=0 while reset=1, instr_valid=0, instr_pc=0.
REQ-029 Reset asserted mid-operation SHALL discard the queue contents and any in-flight response; fetching SHALL restart at address 0 in the first cycle after release.

Configuration
REQ-030 With macro FETCH_BUBBLE_NOP_EN defined, Instruction SHALL be 16'hE000 (NOP) whenever instr_valid=0.
REQ-031 Without FETCH_BUBBLE_NOP_EN, Instruction SHALL be the raw head-slot contents when instr_valid=0 (0 after reset), and consumers SHALL qualify it with instr_valid.

Verification
REQ-032 Release reset, memory mem[i]=16'h2000+i, instr_ready=1 -> mem_addr 0 in cycle 0, instr_valid in cycle 2 with Instruction=16'h2000 and instr_pc=0, then one instruction per cycle.
REQ-033 instr_ready=0 for 10 cycles -> count saturates at 4, mem_req=0 when full, and the head stays 16'h2000 without loss; resume -> 16'h2000..16'h2003 in order.
REQ-034 redirect=1, redirect_target=16'h0040 while the queue is full -> next instr_valid after 3 cycles with instr_pc=16'h0040; no stale entry appears.
REQ-035 fetch_pc=16'hFFFF, no stalls -> instr_pc sequence FFFF, 0000, 0001.
REQ-036 halt=1 with 2 entries queued and 1 in flight -> exactly 3 instructions delivered, then instr_valid=0 and Instruction=16'hE000 (macro defined).
REQ-037 Reset pulse mid-stream -> instr_valid=0 immediately (asynchronous), and the first delivered instruction after release has instr_pc=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - prefetching instruction fetch unit with a credit-limited queue
// Optional feature macro: FETCH_BUBBLE_NOP_EN (drive NOP 16'hE000 on Instruction while instr_valid=0).
// Requests go out combinationally, data returns one cycle later and is queued with its address.
// Outstanding credit (queued + in flight) never exceeds QUEUE_DEPTH, so the queue cannot overflow.
`timescale 1ns/1ps

module instruction_fetch_unit #(
  parameter int ADDR_WIDTH        = 16,
  parameter int QUEUE_DEPTH       = 4,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic                         instr_valid,
  output logic [ADDR_WIDTH-1:0]        instr_pc,
  input  logic                         instr_ready,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_target,
  input  logic                         halt
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  // Fetch side state
  logic [ADDR_WIDTH-1:0]        fetch_pc;
  logic                         inflight;
  logic [ADDR_WIDTH-1:0]        inflight_pc;

  // Queue state
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;
  logic [INSTRUCTION_WIDTH-1:0] data_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]        pc_q   [QUEUE_DEPTH];

  logic [OCC_W-1:0]             occupancy;
  logic                         credit_ok;
  logic                         push;
  logic                         pop;
  logic [INSTRUCTION_WIDTH-1:0] head_data;

  // Credit check, request generation and queue handshakes; redirect overrides everything
  always_comb begin
    occupancy = OCC_W'(count) + OCC_W'(inflight);
    credit_ok = (occupancy < OCC_W'(QUEUE_DEPTH));
    mem_req   = ~reset & ~halt & ~redirect & credit_ok;
    mem_addr  = fetch_pc;
    push      = inflight & ~redirect;
    pop       = instr_valid & instr_ready & ~redirect;
  end

  // Fetch PC, in-flight tracking, pointers and occupancy count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      // Flush: the queue empties and the response now on mem_data is dropped
      fetch_pc    <= redirect_target;
      inflight    <= 1'b0;
      inflight_pc <= redirect_target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (mem_req) begin
        fetch_pc <= fetch_pc + 1'b1;
      end
      inflight    <= mem_req;
      inflight_pc <= fetch_pc;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage: each returning word is written with the address it was fetched from
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr] <= mem_data;
      pc_q[wr_ptr]   <= inflight_pc;
    end
  end

  // Head of queue drives the decoder; the bubble value depends on build configuration
  always_comb begin
    head_data   = data_q[rd_ptr];
    instr_valid = (count != '0);
    instr_pc    = pc_q[rd_ptr];
`ifdef FETCH_BUBBLE_NOP_EN
    Instruction = instr_valid ? head_data : INSTRUCTION_WIDTH'(16'hE000);
`else
    Instruction = head_data;
`endif
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
`timescale 1ns/1ps

module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] Instruction;
  logic        instr_valid;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        halt = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef FETCH_BUBBLE_NOP_EN
  localparam logic [15:0] BUBBLE = 16'hE000;
`else
  localparam logic [15:0] BUBBLE = 16'h0000;
`endif

  instruction_fetch_unit #(
    .ADDR_WIDTH(16), .QUEUE_DEPTH(4), .INSTRUCTION_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .Instruction(Instruction), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt)
  );

  always #5 clock = ~clock;

  // Memory: mem[i] = 16'h2000 + i, returned the cycle after the request
  always @(posedge clock) mem_data <= mem_req ? (16'h2000 + mem_addr) : 16'hBAD0;

  task automatic next_cycle();
    @(negedge clock);
    #1;
  endtask

  // Reset for two cycles, release at a negedge; caller resumes in cycle 0
  task automatic restart(input logic rdy);
    @(negedge clock);
    reset = 1'b1; halt = 1'b0; redirect = 1'b0; instr_ready = rdy;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests_run++; if (instr_pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc: got %h want 0000", instr_pc); end
    tests_run++; if (mem_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    tests_run++; if (Instruction !== BUBBLE) begin tests_failed++; $display("FAIL reset_instr: got %h want %h", Instruction, BUBBLE); end
  endtask

  task automatic test_basic();
    restart(1'b1);
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin tests_failed++; $display("FAIL basic_c0_req: got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_c0_valid: got %b want 0", instr_valid); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0001) begin tests_failed++; $display("FAIL basic_c1: got valid=%b addr=%h want 0/0001", instr_valid, mem_addr); end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      tests_run++;
      if (instr_valid !== 1'b1 || Instruction !== 16'h2000 + 16'(k) || instr_pc !== 16'(k)) begin
        tests_failed++;
        $display("FAIL basic_stream c%0d: got v=%b i=%h pc=%h want 1/%h/%h", k + 2, instr_valid, Instruction, instr_pc, 16'h2000 + 16'(k), 16'(k));
      end
    end
  endtask

  task automatic test_stall();
    restart(1'b0);
    repeat (10) next_cycle();
    tests_run++; if (dut.count !== 3'd4) begin tests_failed++; $display("FAIL stall_count: got %0d want 4", dut.count); end
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_mem_req: got %b want 0", mem_req); end
    tests_run++; if (instr_valid !== 1'b1 || Instruction !== 16'h2000 || instr_pc !== 16'h0000) begin tests_failed++; $display("FAIL stall_head: got v=%b i=%h pc=%h want 1/2000/0000", instr_valid, Instruction, instr_pc); end
    instr_ready = 1'b1;
    #1;
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_resume_req: got %b want 0", mem_req); end
    for (int k = 1; k < 5; k++) begin
      next_cycle();
      tests_run++;
      if (instr_valid !== 1'b1 || Instruction !== 16'h2000 + 16'(k) || instr_pc !== 16'(k)) begin
        tests_failed++;
        $display("FAIL stall_resume k%0d: got v=%b i=%h pc=%h want 1/%h/%h", k, instr_valid, Instruction, instr_pc, 16'h2000 + 16'(k), 16'(k));
      end
    end
  endtask

  task automatic test_redirect();
    restart(1'b0);
    repeat (10) next_cycle();
    redirect = 1'b1; redirect_target = 16'h0040;
    #1;
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL redir_req_in_R: got %b want 0", mem_req); end
    next_cycle();
    redirect = 1'b0; instr_ready = 1'b1;
    #1;
    tests_run++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040) begin tests_failed++; $display("FAIL redir_R1: got v=%b req=%b addr=%h want 0/1/0040", instr_valid, mem_req, mem_addr); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_R2_stale: got %b want 0", instr_valid); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || Instruction !== 16'h2040) begin tests_failed++; $display("FAIL redir_R3: got v=%b pc=%h i=%h want 1/0040/2040", instr_valid, instr_pc, Instruction); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0041 || Instruction !== 16'h2041) begin tests_failed++; $display("FAIL redir_R4: got v=%b pc=%h i=%h want 1/0041/2041", instr_valid, instr_pc, Instruction); end
  endtask

  task automatic test_wrap();
    next_cycle();
    redirect = 1'b1; redirect_target = 16'hFFFF;
    next_cycle();
    redirect = 1'b0;
    #1;
    tests_run++; if (mem_addr !== 16'hFFFF || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_R1: got addr=%h v=%b want FFFF/0", mem_addr, instr_valid); end
    next_cycle();
    tests_run++; if (mem_addr !== 16'h0000) begin tests_failed++; $display("FAIL wrap_addr_R2: got %h want 0000", mem_addr); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || Instruction !== 16'h1FFF) begin tests_failed++; $display("FAIL wrap_R3: got v=%b pc=%h i=%h want 1/FFFF/1FFF", instr_valid, instr_pc, Instruction); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || Instruction !== 16'h2000) begin tests_failed++; $display("FAIL wrap_R4: got v=%b pc=%h i=%h want 1/0000/2000", instr_valid, instr_pc, Instruction); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0001 || Instruction !== 16'h2001) begin tests_failed++; $display("FAIL wrap_R5: got v=%b pc=%h i=%h want 1/0001/2001", instr_valid, instr_pc, Instruction); end
  endtask

  task automatic test_halt();
    restart(1'b0);
    repeat (3) next_cycle();
    halt = 1'b1; instr_ready = 1'b1;
    #1;
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL halt_req: got %b want 0", mem_req); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (instr_valid !== 1'b1 || Instruction !== 16'h2000 + 16'(k) || instr_pc !== 16'(k)) begin
        tests_failed++;
        $display("FAIL halt_drain k%0d: got v=%b i=%h pc=%h want 1/%h/%h", k, instr_valid, Instruction, instr_pc, 16'h2000 + 16'(k), 16'(k));
      end
      next_cycle();
    end
    tests_run++; if (instr_valid !== 1'b0 || Instruction !== BUBBLE || mem_req !== 1'b0) begin tests_failed++; $display("FAIL halt_empty: got v=%b i=%h req=%b want 0/%h/0", instr_valid, Instruction, mem_req, BUBBLE); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_stays_empty: got %b want 0", instr_valid); end
    halt = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (4) next_cycle();
    #1;
    reset = 1'b1;
    #1;
    tests_run++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || instr_pc !== 16'h0000) begin tests_failed++; $display("FAIL midreset_async: got v=%b req=%b pc=%h want 0/0/0000", instr_valid, mem_req, instr_pc); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests_run++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin tests_failed++; $display("FAIL midreset_restart: got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_c1: got %b want 0", instr_valid); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || Instruction !== 16'h2000) begin tests_failed++; $display("FAIL midreset_first: got v=%b pc=%h i=%h want 1/0000/2000", instr_valid, instr_pc, Instruction); end
    next_cycle();
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0001) begin tests_failed++; $display("FAIL midreset_second: got v=%b pc=%h want 1/0001", instr_valid, instr_pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
